fsm_en_gen: RTL and testbench
=============================

// Module: fsm_en_gen
// PURPOSE
//  Synthesizable enable-burst generator and response monitor for 4-bit FSM blocks.
//  - Drives a target FSM's `en` input with a programmable train of bursts: GAP cycles low, then HIGH cycles high, repeated.
//  - Samples the target's `dout` on every en-high cycle, keeping the last value and a running sum.
//  - Sits beside the FSM under test as on-chip stimulus and checker, replacing hand-timed bench drive.
// PARAMETERS
//  GAP_W   8   width of gap_len (cycles en low before each burst)
//  HIGH_W  8   width of high_len (cycles en high per burst)
//  CNT_W   8   width of bursts and burst_cnt
//  DW      4   width of sampled dout_in
//  SUM_W   16  width of dout_sum accumulator
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  start      in   1       1-cycle request; accepted only in IDLE
//  gap_len    in   GAP_W   low cycles before each burst; latched on start
//  high_len   in   HIGH_W  high cycles per burst; latched on start; 0 treated as 1
//  bursts     in   CNT_W   number of bursts; latched on start
//  dout_in    in   DW      target FSM output, sampled while en=1
//  en         out  1       registered enable to target FSM
//  busy       out  1       1 in GAP/HIGH states
//  done       out  1       1-cycle pulse when sequence ends
//  burst_cnt  out  CNT_W   completed bursts in current/last run
//  dout_last  out  DW      dout_in sampled on most recent en-high cycle
//  dout_sum   out  SUM_W   sum of all dout_in samples, modulo 2^SUM_W
// BEHAVIOUR
//  - Reset: state=IDLE; en, busy, done, burst_cnt, dout_last, dout_sum all 0. Reset mid-run aborts immediately; en=0 the cycle after rst is sampled.
//  - States: IDLE, GAP, HIGH, DONE. All outputs registered.
//  - IDLE + start:
//    - Latch config; clear burst_cnt, dout_sum, dout_last.
//    - bursts==0 -> DONE; gap_len==0 -> HIGH; else -> GAP.
//  - GAP: en=0 for exactly gap_len cycles, then -> HIGH.
//  - HIGH:
//    - en=1 for exactly max(high_len,1) cycles.
//    - Each HIGH cycle: dout_last<=dout_in and dout_sum<=dout_sum+dout_in, both taking effect on the next edge.
//    - On last HIGH cycle, burst_cnt+1; if it equals bursts -> DONE, else -> GAP (or HIGH again if gap_len==0, giving a continuous en).
//  - DONE: done=1, busy=0, en=0 for one cycle -> IDLE. burst_cnt, dout_last, dout_sum hold until next accepted start.
//  - Timing: start sampled at edge t -> first en-high cycle t+1+gap_len; done follows the final en-high cycle directly.
//  - start while not IDLE: ignored, no effect on config.
//  - Counters compare exact; no wrap of burst_cnt (max bursts = 2^CNT_W-1).
// CONFIGURATION
//  FSM_EN_GEN_ABORT_EN defined:
//    - Adds input port `abort` (1 bit).
//    - abort=1 in GAP or HIGH -> next state DONE: en=0 and done=1 in that cycle.
//    - burst_cnt keeps completed bursts only; a partial burst is not counted; samples already taken are kept.
//    - abort is ignored in IDLE and DONE.
//  FSM_EN_GEN_ABORT_EN undefined: no abort port; a sequence ends only by completion or rst.
// TESTING
//  1. rst high 3 cycles, start never asserted -> en/busy/done/burst_cnt/dout_sum stay 0.
//  2. gap=10, high=3, bursts=2, start at cycle 0 -> en=1 cycles 11-13 and 24-26, done=1 cycle 27, burst_cnt=2.
//  3. Same as 2, dout_in held 4'h5 -> dout_last=4'h5, dout_sum=16'd30; pulse start at cycle 15 -> ignored, timing unchanged.
//  4. bursts=0 -> done pulses 1 cycle after start, en never high; gap=0, high=0, bursts=3 -> en high 3 consecutive cycles.
//  5. rst asserted at cycle 12 of scenario 2 -> en=0 from cycle 13, all outputs 0, new start runs cleanly.
//  6. (ABORT_EN) scenario 2 with abort at cycle 25 -> en=0 and done=1 at cycle 26, burst_cnt=1.

Source files
------------

// File: rtl/fsm_en_gen.sv
// fsm_en_gen: enable-burst generator and response monitor for small FSM blocks.
// Drives the target's `en` with a train of bursts: gap_len cycles low, then
// max(high_len,1) cycles high, repeated `bursts` times. While en is high the
// target's dout is sampled into dout_last and accumulated into dout_sum.
//
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   start         one-cycle request, accepted only while idle
//   gap_len       low cycles before each burst (latched on start)
//   high_len      high cycles per burst, 0 treated as 1 (latched on start)
//   bursts        number of bursts (latched on start)
//   abort         optional, only with FSM_EN_GEN_ABORT_EN defined
//   dout_in       target FSM output, sampled while en=1
//   en, busy      registered enable and running flag
//   done          one-cycle pulse as the sequence ends
//   burst_cnt     completed bursts of the current/last run
//   dout_last     most recent en-high sample
//   dout_sum      running sum of samples, modulo 2^SUM_W
//
// Optional feature macro: FSM_EN_GEN_ABORT_EN (adds the abort input).
module fsm_en_gen #(
  parameter int GAP_W  = 8,
  parameter int HIGH_W = 8,
  parameter int CNT_W  = 8,
  parameter int DW     = 4,
  parameter int SUM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GAP_W-1:0]  gap_len,
  input  logic [HIGH_W-1:0] high_len,
  input  logic [CNT_W-1:0]  bursts,
`ifdef FSM_EN_GEN_ABORT_EN
  input  logic              abort,
`endif
  input  logic [DW-1:0]     dout_in,
  output logic              en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  burst_cnt,
  output logic [DW-1:0]     dout_last,
  output logic [SUM_W-1:0]  dout_sum
);

  localparam int CW = (GAP_W > HIGH_W) ? GAP_W : HIGH_W;

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_HIGH, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [HIGH_W-1:0] high_q, high_d;
  logic [CNT_W-1:0]  bursts_q, bursts_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [DW-1:0]     dout_last_q, dout_last_d;
  logic [SUM_W-1:0]  dout_sum_q, dout_sum_d;
  logic              en_q, busy_q, done_q;
  logic [HIGH_W-1:0] high_eff;
  logic              abort_w;

`ifdef FSM_EN_GEN_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign high_eff = (high_len == '0) ? HIGH_W'(1) : high_len;

  // cnt_q is a down-counter loaded with (phase length - 1); a phase ends
  // on the cycle it reads zero.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    high_d      = high_q;
    bursts_d    = bursts_q;
    cnt_d       = cnt_q;
    burst_cnt_d = burst_cnt_q;
    dout_last_d = dout_last_q;
    dout_sum_d  = dout_sum_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          gap_d       = gap_len;
          high_d      = high_eff;
          bursts_d    = bursts;
          burst_cnt_d = '0;
          dout_last_d = '0;
          dout_sum_d  = '0;
          if (bursts == '0) begin
            state_d = S_DONE;
          end else if (gap_len == '0) begin
            state_d = S_HIGH;
            cnt_d   = CW'(high_eff) - CW'(1);
          end else begin
            state_d = S_GAP;
            cnt_d   = CW'(gap_len) - CW'(1);
          end
        end
      end
      S_GAP: begin
        if (abort_w) begin
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          state_d = S_HIGH;
          cnt_d   = CW'(high_q) - CW'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HIGH: begin
        // Every en-high cycle is sampled, including one that gets aborted.
        dout_last_d = dout_in;
        dout_sum_d  = dout_sum_q + SUM_W'(dout_in);
        if (abort_w) begin
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
          if (burst_cnt_d == bursts_q) begin
            state_d = S_DONE;
          end else if (gap_q == '0) begin
            state_d = S_HIGH;
            cnt_d   = CW'(high_q) - CW'(1);
          end else begin
            state_d = S_GAP;
            cnt_d   = CW'(gap_q) - CW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Flag outputs are registered copies of the next-state decode, so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      high_q      <= '0;
      bursts_q    <= '0;
      cnt_q       <= '0;
      burst_cnt_q <= '0;
      dout_last_q <= '0;
      dout_sum_q  <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      high_q      <= high_d;
      bursts_q    <= bursts_d;
      cnt_q       <= cnt_d;
      burst_cnt_q <= burst_cnt_d;
      dout_last_q <= dout_last_d;
      dout_sum_q  <= dout_sum_d;
      en_q        <= (state_d == S_HIGH);
      busy_q      <= (state_d == S_GAP) || (state_d == S_HIGH);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign en        = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign burst_cnt = burst_cnt_q;
  assign dout_last = dout_last_q;
  assign dout_sum  = dout_sum_q;

endmodule

// File: tb/tb_fsm_en_gen.sv
// Self-checking bench for fsm_en_gen: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// timeline model (outputs computed from elapsed cycles since start).
module tb_fsm_en_gen;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] gap_len, high_len, bursts;
  logic [3:0] dout_in;
  logic       abort;
  logic       en, busy, done;
  logic [7:0] burst_cnt;
  logic [3:0] dout_last;
  logic [15:0] dout_sum;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  fsm_en_gen #(.GAP_W(8), .HIGH_W(8), .CNT_W(8), .DW(4), .SUM_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .gap_len(gap_len), .high_len(high_len), .bursts(bursts),
`ifdef FSM_EN_GEN_ABORT_EN
    .abort(abort),
`endif
    .dout_in(dout_in),
    .en(en), .busy(busy), .done(done),
    .burst_cnt(burst_cnt), .dout_last(dout_last), .dout_sum(dout_sum)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Timeline model: m_t = cycles since the accepting edge (1 = first cycle).
  bit m_active, m_ab;
  int m_t, m_g, m_h, m_b, m_cnt, m_last, m_sum;
  bit e_en, e_busy, e_done;

  always @(posedge clk) begin
    bit ab;
    int p, endt;
`ifdef FSM_EN_GEN_ABORT_EN
    ab = abort;
`else
    ab = 1'b0;
`endif
    if (rst) begin
      m_active = 0; m_ab = 0; m_cnt = 0; m_last = 0; m_sum = 0;
    end else begin
      if (e_en) begin
        m_last = dout_in;
        m_sum  = (m_sum + dout_in) % 65536;
      end
      if (m_active) begin
        if (e_done) m_active = 0;
        else if (ab && e_busy) m_ab = 1;
        else m_t++;
      end else if (start) begin
        m_active = 1; m_ab = 0; m_t = 1;
        m_g = gap_len; m_h = (high_len == 0) ? 1 : high_len; m_b = bursts;
        m_cnt = 0; m_last = 0; m_sum = 0;
      end
    end
    e_en = 0; e_busy = 0; e_done = 0;
    if (m_active) begin
      if (m_ab) e_done = 1;
      else begin
        p      = m_g + m_h;
        endt   = (m_b == 0) ? 1 : m_b * p + 1;
        e_done = (m_t == endt);
        e_busy = (m_t < endt);
        e_en   = e_busy && (((m_t - 1) % p) >= m_g);
        m_cnt  = ((m_t - 1) / p < m_b) ? (m_t - 1) / p : m_b;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("en", en, e_en);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("burst_cnt", burst_cnt, m_cnt);
      chk("dout_last", dout_last, m_last);
      chk("dout_sum", dout_sum, m_sum);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cfg(input int g, input int h, input int b);
    gap_len = 8'(g); high_len = 8'(h); bursts = 8'(b);
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; dout_in = 0;
    cfg(0, 0, 0);
    tick();
    chk_on = 1;
    // Reset held, start never asserted.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_en", en, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      chk("rst_cnt", burst_cnt, 0); chk("rst_sum", dout_sum, 0);
    end
    rst = 0;
    tick(); tick();
    chk("idle_en", en, 0);

    // gap=10 high=3 bursts=2, dout=5; a late start with new config is ignored.
    cfg(10, 3, 2); dout_in = 4'h5; start = 1;
    for (int c = 1; c <= 28; c++) begin
      tick();
      if (c == 1) start = 0;
      if (c == 15) begin start = 1; cfg(1, 7, 9); end
      if (c == 16) start = 0;
      chk("s2_en", en, ((c >= 11 && c <= 13) || (c >= 24 && c <= 26)) ? 1 : 0);
      chk("s2_done", done, (c == 27) ? 1 : 0);
      if (c == 27) begin
        chk("s2_cnt", burst_cnt, 2);
        chk("s3_last", dout_last, 5);
        chk("s3_sum", dout_sum, 30);
      end
    end

    // bursts=0: immediate done, no en.
    tick(); tick();
    cfg(4, 2, 0); start = 1;
    tick(); start = 0;
    chk("b0_done", done, 1); chk("b0_en", en, 0); chk("b0_busy", busy, 0);
    tick();
    chk("b0_done2", done, 0);

    // gap=0 high=0 bursts=3: continuous en for 3 cycles.
    tick(); tick();
    cfg(0, 0, 3); start = 1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) start = 0;
      chk("g0_en", en, (c <= 3) ? 1 : 0);
      chk("g0_done", done, (c == 4) ? 1 : 0);
    end

    // Reset mid-run, then a clean new run.
    tick();
    cfg(10, 3, 2); start = 1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) start = 0;
      if (c == 12) rst = 1;
    end
    chk("mr_en", en, 0); chk("mr_busy", busy, 0); chk("mr_cnt", burst_cnt, 0);
    chk("mr_sum", dout_sum, 0); chk("mr_last", dout_last, 0);
    rst = 0;
    tick();
    cfg(2, 2, 1); start = 1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) start = 0;
      chk("mr2_en", en, (c == 3 || c == 4) ? 1 : 0);
      chk("mr2_done", done, (c == 5) ? 1 : 0);
    end

`ifdef FSM_EN_GEN_ABORT_EN
    tick();
    cfg(10, 3, 2); start = 1;
    for (int c = 1; c <= 27; c++) begin
      tick();
      if (c == 1) start = 0;
      if (c == 25) abort = 1;
      if (c == 26) begin
        abort = 0;
        chk("ab_en", en, 0); chk("ab_done", done, 1); chk("ab_cnt", burst_cnt, 1);
      end
      if (c == 27) chk("ab_done2", done, 0);
    end
`endif

    // Randomized traffic; the per-cycle compare process checks everything.
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst     = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 3) == 0);
      cfg($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 4));
      dout_in = 4'($urandom);
      abort   = ($urandom_range(0, 39) == 0);
    end
    rst = 1; start = 0; abort = 0;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
